// File: rtl/reg_alu_core_param.sv
// Parametrised register bank + ALU with an edge-started 4-state execute FSM.
// Optional ZERO_REG_EN: R0 hardwired to zero, writes to it discarded.
module reg_alu_core_param #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 4,
    parameter  int DISP_W = 16,
    localparam int NREG   = 2 ** ADDR_W,
    localparam int NSLICE = DATA_W / DISP_W,
    localparam int DSEL_W = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              execute,
    input  logic [3:0]        alu_op,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DSEL_W-1:0] disp_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags,
    output logic [DISP_W-1:0] display_output
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_req_t;

    state_t                       state_q, state_d;
    logic                         prev_q, prev_d;
    op_req_t                      req_q, req_d;
    logic [DATA_W-1:0]            res_q, res_d;
    logic [3:0]                   rflags_q, rflags_d;
    logic [3:0]                   flags_q, flags_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [NREG-1:0][DATA_W-1:0]  regs_q, regs_d;

    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic              reserved_op;

    assign reserved_op = (req_q.op[3:2] == 2'b11);

    // ALU on the operands latched in READ
    always_comb begin
        logic [DATA_W:0]   add_full;
        logic [DATA_W:0]   sub_full;
        logic [SH_W-1:0]   sh;
        logic              c;
        logic              v;
        add_full = {1'b0, req_q.a} + {1'b0, req_q.b};
        sub_full = {1'b0, req_q.a} - {1'b0, req_q.b};
        sh       = req_q.b[SH_W-1:0];
        c        = 1'b0;
        v        = 1'b0;
        alu_res  = '0;
        case (req_q.op)
            OP_ADD: begin
                alu_res = add_full[DATA_W-1:0];
                c = add_full[DATA_W];
                v = (req_q.a[DATA_W-1] == req_q.b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != req_q.a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[DATA_W-1:0];
                c = ~sub_full[DATA_W];  // carry means "no borrow"
                v = (req_q.a[DATA_W-1] != req_q.b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != req_q.a[DATA_W-1]);
            end
            OP_AND:  alu_res = req_q.a & req_q.b;
            OP_OR:   alu_res = req_q.a | req_q.b;
            OP_XOR:  alu_res = req_q.a ^ req_q.b;
            OP_SLL:  alu_res = req_q.a << sh;
            OP_SRL:  alu_res = req_q.a >> sh;
            OP_SRA:  alu_res = $signed(req_q.a) >>> sh;
            OP_NOR:  alu_res = ~(req_q.a | req_q.b);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(req_q.a) < $signed(req_q.b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (req_q.a < req_q.b)};
            OP_MOV:  alu_res = req_q.a;
            default: alu_res = '0;
        endcase
        alu_flags = {(alu_res == '0), alu_res[DATA_W-1], c, v};
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = execute;
        req_d    = req_q;
        res_d    = res_q;
        rflags_d = rflags_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        regs_d   = regs_q;
        case (state_q)
            S_IDLE: begin
                if (execute && !prev_q) state_d = S_READ;
            end
            S_READ: begin
                req_d.op = alu_op;
                req_d.rd = rd;
                req_d.a  = regs_q[rs];
                req_d.b  = regs_q[rt];
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                res_d    = alu_res;
                rflags_d = alu_flags;
                state_d  = S_WB;
            end
            S_WB: begin
                // Flags commit with the write so an aborted op leaves no trace
                if (reserved_op) begin
                    err_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    flags_d = rflags_q;
                    regs_d[req_q.rd] = res_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef ZERO_REG_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prev_q   <= 1'b0;
            req_q    <= '0;
            res_q    <= '0;
            rflags_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_W'(i);
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            req_q    <= req_d;
            res_q    <= res_d;
            rflags_q <= rflags_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign flags = flags_q;

    // Display slice of the live rd register; unmapped selects read zero
    always_comb begin
        logic [DATA_W-1:0] disp_word;
        disp_word      = regs_q[rd];
        display_output = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (disp_sel == DSEL_W'(s)) display_output = disp_word[s*DISP_W +: DISP_W];
        end
    end

endmodule

// File: tb/tb_reg_alu_core_param.sv
// Scoreboard bench for reg_alu_core_param: stimulus pushes expected responses,
// a negedge monitor pops and checks each done/err pulse (kind, flags, cycle).
module tb_reg_alu_core_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        execute;
    logic [3:0]  alu_op;
    logic [3:0]  rs, rt, rd;
    logic [0:0]  disp_sel;
    logic        busy, done, err;
    logic [3:0]  flags;
    logic [15:0] display_output;

    reg_alu_core_param #(.DATA_W(32), .ADDR_W(4), .DISP_W(16)) dut (
        .clk(clk), .rst(rst), .execute(execute), .alu_op(alu_op),
        .rs(rs), .rt(rt), .rd(rd), .disp_sel(disp_sel),
        .busy(busy), .done(done), .err(err), .flags(flags),
        .display_output(display_output)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [3:0] flags;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [3:0] fl, input int at);
        exp_t e;
        e.is_err = is_err;
        e.flags  = fl;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (done || err) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, done, err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_kind", {30'b0, done, err}, mon_e.is_err ? 32'd1 : 32'd2);
                chk("resp_flags", {28'b0, flags}, {28'b0, mon_e.flags});
                chk("resp_cycle", mon_e.cyc, cyc);
            end
        end
    end

    task automatic rd_chk(input string name, input logic [3:0] r, input logic s,
                          input logic [15:0] exp);
        rd = r;
        disp_sel = s;
        #1;
        chk(name, {16'b0, display_output}, {16'b0, exp});
    endtask

    // One op with a single-cycle execute pulse; checks the 3-cycle busy window
    // and scrambles the operand inputs once READ has latched them.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                          input logic is_err, input logic [3:0] fl);
        @(negedge clk);
        alu_op = op; rs = a; rt = b; rd = d; execute = 1'b1;
        push_exp(is_err, fl, cyc + 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) execute = 1'b0;
            if (k == 2) begin
                rs = ~a; rt = ~b; rd = ~d; alu_op = 4'hC;
            end
            chk({name, "_busy"}, {31'b0, busy}, (k <= 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; execute = 1'b0; alu_op = '0; rs = '0; rt = '0; rd = '0; disp_sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_flags", {28'b0, flags}, 32'd0);
        rd_chk("rst_r7_lo", 4'd7, 1'b0, 16'h0007);
        rd_chk("rst_r7_hi", 4'd7, 1'b1, 16'h0000);

        run_op("add", 4'h0, 4'd2, 4'd3, 4'd14, 1'b0, 4'b0000);
        rd_chk("add_lo", 4'd14, 1'b0, 16'h0005);
        rd_chk("add_hi", 4'd14, 1'b1, 16'h0000);

        run_op("sub", 4'h1, 4'd1, 4'd5, 4'd9, 1'b0, 4'b0100);
        rd_chk("sub_lo", 4'd9, 1'b0, 16'hFFFC);
        rd_chk("sub_hi", 4'd9, 1'b1, 16'hFFFF);

        run_op("sra", 4'h7, 4'd9, 4'd2, 4'd10, 1'b0, 4'b0100);
        rd_chk("sra_lo", 4'd10, 1'b0, 16'hFFFF);
        rd_chk("sra_hi", 4'd10, 1'b1, 16'hFFFF);

        run_op("sll", 4'h5, 4'd1, 4'd15, 4'd11, 1'b0, 4'b0000);
        rd_chk("sll_lo", 4'd11, 1'b0, 16'h8000);
        rd_chk("sll_hi", 4'd11, 1'b1, 16'h0000);

        run_op("sltu", 4'hA, 4'd15, 4'd9, 4'd13, 1'b0, 4'b0000);
        rd_chk("sltu_lo", 4'd13, 1'b0, 16'h0001);

        run_op("slt", 4'h9, 4'd9, 4'd15, 4'd3, 1'b0, 4'b0000);
        rd_chk("slt_lo", 4'd3, 1'b0, 16'h0001);

        // 0xFFFFFFFF + 1 wraps to zero with carry out
        run_op("add_wrap", 4'h0, 4'd10, 4'd1, 4'd5, 1'b0, 4'b1010);
        rd_chk("add_wrap_lo", 4'd5, 1'b0, 16'h0000);
        rd_chk("add_wrap_hi", 4'd5, 1'b1, 16'h0000);

        run_op("srl", 4'h6, 4'd10, 4'd1, 4'd7, 1'b0, 4'b0000);
        rd_chk("srl_hi", 4'd7, 1'b1, 16'h7FFF);

        // 0x7FFFFFFF + 1 is a signed overflow
        run_op("add_ovf", 4'h0, 4'd7, 4'd1, 4'd6, 1'b0, 4'b0101);
        rd_chk("add_ovf_hi", 4'd6, 1'b1, 16'h8000);
        rd_chk("add_ovf_lo", 4'd6, 1'b0, 16'h0000);

        run_op("xor", 4'h4, 4'd7, 4'd6, 4'd2, 1'b0, 4'b0100);
        rd_chk("xor_lo", 4'd2, 1'b0, 16'hFFFF);

        run_op("nor", 4'h8, 4'd2, 4'd0, 4'd15, 1'b0, 4'b1000);
        rd_chk("nor_lo", 4'd15, 1'b0, 16'h0000);

        run_op("mov", 4'hB, 4'd14, 4'd9, 4'd12, 1'b0, 4'b0000);
        rd_chk("mov_lo", 4'd12, 1'b0, 16'h0005);

        run_op("or", 4'h3, 4'd11, 4'd14, 4'd13, 1'b0, 4'b0000);
        rd_chk("or_lo", 4'd13, 1'b0, 16'h8005);

        run_op("and", 4'h2, 4'd10, 4'd13, 4'd14, 1'b0, 4'b0000);
        rd_chk("and_lo", 4'd14, 1'b0, 16'h8005);

        // execute held high for 10 cycles: exactly one operation
        @(negedge clk);
        alu_op = 4'h0; rs = 4'd4; rt = 4'd4; rd = 4'd4; execute = 1'b1;
        push_exp(1'b0, 4'b0000, cyc + 4);
        repeat (10) @(negedge clk);
        execute = 1'b0;
        repeat (2) @(negedge clk);
        rd_chk("hold_r4", 4'd4, 1'b0, 16'h0008);

        // a second rising edge while busy must be dropped, not queued
        @(negedge clk);
        alu_op = 4'h0; rs = 4'd4; rt = 4'd1; rd = 4'd8; execute = 1'b1;
        push_exp(1'b0, 4'b0000, cyc + 4);
        @(negedge clk); execute = 1'b0;
        @(negedge clk); execute = 1'b1;
        @(negedge clk); execute = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk("busy_edge_r8", 4'd8, 1'b0, 16'h0009);

        // reset while the op sits in EXEC: no write, no pulse
        @(negedge clk);
        alu_op = 4'h0; rs = 4'd2; rt = 4'd3; rd = 4'd12; execute = 1'b1;
        @(negedge clk); execute = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_flags", {28'b0, flags}, 32'd0);
        rd_chk("abort_r12", 4'd12, 1'b0, 16'h000C);
        rd_chk("abort_r4", 4'd4, 1'b0, 16'h0004);

        // reserved opcode: err instead of done, flags and registers untouched
        run_op("sub2", 4'h1, 4'd1, 4'd5, 4'd9, 1'b0, 4'b0100);
        run_op("rsvd", 4'hD, 4'd2, 4'd3, 4'd6, 1'b1, 4'b0100);
        rd_chk("rsvd_r6", 4'd6, 1'b0, 16'h0006);
        chk("rsvd_flags", {28'b0, flags}, 32'h4);

        run_op("add_r0", 4'h0, 4'd1, 4'd1, 4'd0, 1'b0, 4'b0000);
`ifdef ZERO_REG_EN
        rd_chk("r0_lo", 4'd0, 1'b0, 16'h0000);
`else
        rd_chk("r0_lo", 4'd0, 1'b0, 16'h0002);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_alu_core_param.md
Name: reg_alu_core_param

Overview:
Parametrised register-bank/ALU core. It is the next generation of the team's 16x32 register/ALU top, generalised in data width, register count and display width. Compared with that block it adds a 4-bit opcode space and an edge-triggered multi-cycle execute FSM with busy/done/err handshake. It also adds Z/N/C/V status flags and a general display slice mux. It sits between the front-panel/DFT controls and the future datapath controller.

Parameters:
DATA_W, 32, register/ALU width (multiple of DISP_W, >=8, power of 2)
ADDR_W, 4, register address width; NREG = 2**ADDR_W
DISP_W, 16, display slice width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
execute  in  1  start request, rising-edge sensitive
alu_op  in  4  operation code
rs  in  ADDR_W  source A address
rt  in  ADDR_W  source B / shift-amount address
rd  in  ADDR_W  destination address; also display address
disp_sel  in  max(1,clog2(DATA_W/DISP_W))  display slice index
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse on writeback
err  out  1  one-cycle pulse on a reserved opcode (in place of done)
flags  out  4  {Z,N,C,V} from the last legal operation
display_output  out  DISP_W  slice disp_sel of R[rd]

Behaviour:
- Reset (rst=1 at a clk edge): R[i]=i mod 2**DATA_W; state IDLE; busy=0, done=0, err=0, flags=0; execute edge detector prev=0.
- Reset mid-operation: aborts the operation. No register write occurs and no done/err pulse is produced.
- Start: condition is execute=1 and prev=0 while in IDLE. execute held high starts exactly one operation. Rising edges seen outside IDLE are ignored and are not queued.
- FSM:
  - IDLE -> READ on start.
  - READ: latch alu_op, rd, A=R[rs], B=R[rt] -> EXEC.
  - EXEC: compute; register result and flags -> WB.
  - WB: write R[rd_latched]; pulse done (or err) -> IDLE.
- busy=1 in READ, EXEC and WB.
- Latency: the start edge is edge 0. The register write and the done pulse both occur at edge 3. A new start is accepted at edge 4 at the earliest.
- rs/rt/rd/alu_op may change after READ without affecting the operation in flight.
- Opcodes:
  - 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL (A<<sh), 0110 SRL, 0111 SRA (A>>>sh).
  - 1000 NOR.
  - 1001 SLT (signed A<B -> 1, else 0), 1010 SLTU (unsigned).
  - 1011 MOV (A).
  - 1100-1111 reserved: no register write, flags unchanged, err pulses instead of done.
- Shift amount: sh = B[clog2(DATA_W)-1:0]; upper bits of B are ignored.
- Arithmetic: wraps modulo 2**DATA_W.
- Flags:
  - Z = (result==0); N = result[DATA_W-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = no-borrow (A>=B unsigned); V = signed overflow.
  - All other legal ops: C=0, V=0.
- Display: combinational, R[rd][disp_sel*DISP_W +: DISP_W], using the live rd input. It reflects the new value from the cycle after the write.
- disp_sel out of range: display_output = 0.
- Same-register cases (rd==rs==rt): the values read are the old values latched in READ.

Optional Feature:
ZERO_REG_EN
- Defined: R0 is hardwired to 0 (also 0 at reset). Writes to R0 are discarded, but done and flags still reflect the computed result.
- Undefined: R0 is an ordinary register with reset value 0.

Test Plan:
- Reset; rd=7, disp_sel=0 -> display 0x0007; disp_sel=1 -> 0x0000; busy=done=0, flags=0.
- ADD rs=2 rt=3 rd=14, single execute pulse -> busy high for 3 cycles, done pulse at edge 3, R14=0x00000005, flags Z=0 N=0 C=0 V=0.
- SUB rs=1 rt=5 rd=9 -> R9=0xFFFFFFFC with N=1, C=0. Then SRA rs=9 rt=2 rd=10 -> R10=0xFFFFFFFF.
- SLL rs=1 rt=15 rd=11 -> R11=0x00008000, display (disp_sel=0) 0x8000 / (disp_sel=1) 0x0000. SLTU rs=15 rt=9 -> 1 (15 < 0xFFFFFFFC unsigned).
- execute held high 10 cycles with ADD rs=rt=rd=4 -> exactly one op, R4=8. A second edge during busy is ignored.
- rst asserted in EXEC of ADD rd=12 -> R12=12, no done. Reserved op 1101 -> err pulse, no write, flags unchanged. With ZERO_REG_EN: ADD rs=1 rt=1 rd=0 -> done pulses, R0 reads 0.
